// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response channel bundle for the data-memory responder
//
// Purpose: groups the valid/ready request channel and the valid/ready
// response channel between a requester (master) and the responder (slave).
// Signals:
//   req_valid  master->slave  request present
//   req_ready  slave->master  responder can accept a request
//   req_write  master->slave  1 = store, 0 = load
//   req_addr   master->slave  byte address
//   req_wdata  master->slave  store data
//   resp_valid slave->master  response present
//   resp_ready master->slave  requester consumes response
//   resp_rdata slave->master  load data (0 for stores and errors)
//   resp_err   slave->master  misaligned or out-of-range access
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle word-addressed data memory with valid/ready load/store channels
//
// Purpose: answers one load/store request at a time after LATENCY wait
// cycles, with backpressure on the response channel.
// Ports:
//   clk   clock, all state on rising edge
//   rst   asynchronous active-low reset (0 = reset asserted)
//   bus   slave side of data_mem_responder_if (request + response channels)
//   busy  high whenever the FSM is not IDLE
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   data_mem_responder_if.slave        bus,
   output logic                       busy
);

   localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);
   localparam logic [3:0]  LAT     = 4'(LATENCY);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        write_q, write_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0]   mem [DEPTH_WORDS];
   logic          access_err;
   logic          mem_we;
   logic [AW-1:0] word_idx;

   // Full upper-bit compare so out-of-range addresses never alias into the RAM.
   assign access_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= DEPTH_W);
   assign word_idx   = addr_q[AW+1:2];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               write_d = bus.req_write;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               cnt_d   = LAT;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = RESP;
               err_d   = access_err;
               rdata_d = 32'd0;
               if (!access_err) begin
                  if (write_q) mem_we  = 1'b1;
                  else         rdata_d = mem[word_idx];
               end
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               rdata_d = 32'd0;
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         write_q <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // RAM is never reset; mem_we is low while reset holds state_q in IDLE,
   // so an abandoned store cannot commit.
   always_ff @(posedge clk) begin
      if (mem_we) mem[word_idx] <= wdata_q;
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder (LATENCY=2 and LATENCY=0 builds)
module tb_data_mem_responder;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic busy_a, busy_b;

   always #5 clk = ~clk;

   data_mem_responder_if a_if();
   data_mem_responder_if b_if();

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_a (
      .clk(clk), .rst(rst), .bus(a_if.slave), .busy(busy_a)
   );
   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut_b (
      .clk(clk), .rst(rst), .bus(b_if.slave), .busy(busy_b)
   );

   assign b_if.resp_ready = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;
   logic [32:0] sb_a[$];
   logic [32:0] sb_b[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitors: pop and compare on every response handshake.
   always @(negedge clk) begin
      if (rst && a_if.resp_valid && a_if.resp_ready) begin
         if (sb_a.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL a_unexpected_resp: got rdata %h with empty scoreboard", a_if.resp_rdata);
         end else begin
            logic [32:0] e;
            e = sb_a.pop_front();
            chk("a_rdata", a_if.resp_rdata, e[31:0]);
            chk("a_err", 32'(a_if.resp_err), 32'(e[32]));
         end
      end
   end

   always @(negedge clk) begin
      if (rst && b_if.resp_valid && b_if.resp_ready) begin
         if (sb_b.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL b_unexpected_resp: got rdata %h with empty scoreboard", b_if.resp_rdata);
         end else begin
            logic [32:0] e;
            e = sb_b.pop_front();
            chk("b_rdata", b_if.resp_rdata, e[31:0]);
            chk("b_err", 32'(b_if.resp_err), 32'(e[32]));
         end
      end
   end

   // All tasks are entered and left 1 time unit after a rising edge.
   task automatic issue_a(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
      a_if.req_valid = 1'b1;
      a_if.req_write = wr;
      a_if.req_addr  = addr;
      a_if.req_wdata = wdata;
      @(posedge clk); #1;
      a_if.req_valid = 1'b0;
   endtask

   task automatic wait_resp_a(output int lat);
      lat = 0;
      while (!a_if.resp_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic consume_a();
      a_if.resp_ready = 1'b1;
      @(posedge clk); #1;
      a_if.resp_ready = 1'b0;
      chk("a_ready_after_consume", 32'(a_if.req_ready), 32'd1);
      chk("a_busy_after_consume", 32'(busy_a), 32'd0);
   endtask

   task automatic txn_a(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input bit exp_err, input int hold);
      int lat;
      sb_a.push_back({exp_err, exp_rd});
      issue_a(wr, addr, wdata);
      wait_resp_a(lat);
      chk("a_latency", 32'(lat), 32'd3);
      for (int i = 0; i < hold; i++) begin
         chk("a_hold_valid", 32'(a_if.resp_valid), 32'd1);
         chk("a_hold_rdata", a_if.resp_rdata, exp_rd);
         chk("a_hold_req_ready", 32'(a_if.req_ready), 32'd0);
         @(posedge clk); #1;
      end
      consume_a();
   endtask

   task automatic txn_b(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd);
      int e, lat, low;
      sb_b.push_back({1'b0, exp_rd});
      b_if.req_valid = 1'b1;
      b_if.req_write = wr;
      b_if.req_addr  = addr;
      b_if.req_wdata = wdata;
      @(posedge clk); #1;
      b_if.req_valid = 1'b0;
      e = 0; lat = -1; low = 0;
      while (!b_if.req_ready && e < 50) begin
         if (b_if.resp_valid && lat < 0) lat = e;
         low++;
         @(posedge clk); #1;
         e++;
      end
      chk("b_latency", 32'(lat), 32'd1);
      chk("b_ready_low_cycles", 32'(low), 32'd2);
   endtask

   initial begin
      int lat;
      a_if.req_valid = 1'b0; a_if.req_write = 1'b0; a_if.req_addr = '0;
      a_if.req_wdata = '0;   a_if.resp_ready = 1'b0;
      b_if.req_valid = 1'b0; b_if.req_write = 1'b0; b_if.req_addr = '0;
      b_if.req_wdata = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(a_if.req_ready), 32'd1);
      chk("rst_resp_valid", 32'(a_if.resp_valid), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_b_req_ready", 32'(b_if.req_ready), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;

      // Store/load round trip
      txn_a(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
      txn_a(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);

      // Backpressure
      txn_a(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5);

      // Errors and no aliasing of upper bits
      txn_a(1'b1, 32'h12, 32'h0BADF00D, 32'h0, 1'b1, 0);
      txn_a(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
      txn_a(1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 0);
      txn_a(1'b1, 32'h410, 32'h00000077, 32'h0, 1'b1, 0);
      txn_a(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);

      // Asynchronous reset while a load response is pending
      issue_a(1'b0, 32'h10, 32'h0);
      wait_resp_a(lat);
      chk("pre_rst_rdata", a_if.resp_rdata, 32'hDEADBEEF);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_resp_valid", 32'(a_if.resp_valid), 32'd0);
      chk("async_rst_rdata", a_if.resp_rdata, 32'd0);
      chk("async_rst_err", 32'(a_if.resp_err), 32'd0);
      chk("async_rst_busy", 32'(busy_a), 32'd0);
      chk("async_rst_req_ready", 32'(a_if.req_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Committed store survives reset in RESP
      issue_a(1'b1, 32'h30, 32'hCAFEF00D);
      wait_resp_a(lat);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      txn_a(1'b0, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0, 0);

      // LATENCY=0 build
      txn_b(1'b1, 32'h8, 32'h55AA55AA, 32'h0);
      txn_b(1'b0, 32'h8, 32'h0, 32'h55AA55AA);

      // Reset mid-BUSY abandons the store
      txn_a(1'b1, 32'h20, 32'hAAAAAAAA, 32'h0, 1'b0, 0);
      issue_a(1'b1, 32'h20, 32'h12345678);
      rst = 1'b0;
      #1;
      chk("mid_busy_rst_ready", 32'(a_if.req_ready), 32'd1);
      chk("mid_busy_rst_busy", 32'(busy_a), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      txn_a(1'b0, 32'h20, 32'h0, 32'hAAAAAAAA, 1'b0, 0);

      @(posedge clk); #1;
      chk("sb_a_drained", 32'(sb_a.size()), 32'd0);
      chk("sb_b_drained", 32'(sb_b.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
